cpu_clock_ctrl: RTL and testbench
=================================

Name: cpu_clock_ctrl

Overview:
- Run/step/halt clock sequencer for the single-cycle CPU.
- Derives the CPU clock from the board clock with a runtime-programmable divider.
- Supports free-run, single-step (from a push button) and halt, and counts executed CPU cycles.
- Sits between the board oscillator and the CPU/memory clock inputs in the top level.

Parameters:
DIV_W, 32, width of divider register and div_value
CNT_W, 32, width of cycle_count
DEFAULT_DIV, 0, divider value after reset (half-period = DEFAULT_DIV+1 clock_in cycles)
AUTO_RUN, 0, 1 = enter RUN after reset instead of HALT

Ports:
clock_in  input  1  board clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
run_req  input  1  level, synchronous; request free-run
halt_req  input  1  level, synchronous; request halt
step_req  input  1  asynchronous push button, active-high; one CPU cycle per press
div_load  input  1  one-cycle strobe; load div_value
div_value  input  DIV_W  new half-period minus one
clock_out  output  1  CPU clock
mem_clock_out  output  1  memory clock
state  output  2  0=HALT, 1=RUN, 2=STEP
cycle_count  output  CNT_W  number of clock_out rising edges since reset
busy  output  1  high while state != HALT

Behaviour:
- Interface: one clock (clock_in); reset is asynchronous and active-high (reset).
- Reset values:
  - clock_out=0, cycle_count=0, div_cnt=0, div_reg=DEFAULT_DIV.
  - state=HALT, or RUN if AUTO_RUN=1.
  - busy follows state.
  - Synchronizer flops cleared.
- mem_clock_out = clock_in, combinational and ungated; memory is always clocked.
- Divider (only when state != HALT):
  - div_cnt counts 0..div_reg.
  - At div_cnt==div_reg: clock_out toggles and div_cnt returns to 0.
  - div_reg=0 gives clock_out = clock_in/2.
  - In HALT, div_cnt is held at 0.
- cycle_count increments on the clock_in edge where clock_out goes 0->1; it wraps modulo 2^CNT_W.
- div_load:
  - In HALT: div_reg updates on the next edge.
  - Otherwise: the value is held pending and applied at the next clock_out falling toggle (period boundary).
  - A later div_load overwrites the pending value.
- step_req path:
  - Synchronized by 2 flops, plus a third flop for rising-edge detection.
  - If step_req is first sampled high at edge k, step_pulse is high during the cycle after edge k+1.
- FSM (request priority: halt_req > step_pulse > run_req):
  - HALT: run_req -> RUN; step_pulse -> STEP. Otherwise stay.
  - RUN: while halt_req is high, the current period completes and the FSM moves to HALT on the edge where clock_out falls. If clock_out is already 0, it moves to HALT at the next edge with div_cnt==div_reg, without toggling. step_pulse is ignored.
  - STEP: exactly one full period (one rise, one fall) is generated, then HALT on the falling edge. halt_req and step_pulse are ignored.
- Invariant: clock_out is always 0 while in HALT, so there are no runt pulses.
- Step latency with div_reg=D: state=STEP at edge k+2; clock_out rises at edge k+3+D and falls at k+4+2D, with HALT on that same edge.
- A held button produces exactly one step; release and re-press are required for the next.
- Asynchronous reset mid-period forces clock_out=0 immediately.

Optional Feature:
Macro: CPU_CLOCK_CTRL_BREAK_EN
- With the macro: adds input break_cycle [CNT_W] and output break_hit [1] (reset 0).
  - In RUN, when cycle_count==break_cycle and clock_out is 0, the FSM moves to HALT at the next period boundary and break_hit is set.
  - break_hit is sticky; it is cleared on the edge that leaves HALT.
- Without the macro: neither port exists and the FSM is as above.

Test Plan:
- Reset with AUTO_RUN=0, DEFAULT_DIV=0 -> clock_out=0, state=0, cycle_count=0. run_req=1 -> clock_out toggles every clock_in edge; cycle_count=5 after 10 clock_in edges in RUN.
- div_load with div_value=3 while RUN -> current period finishes at the old rate; subsequent half-periods are 4 clock_in cycles.
- HALT, D=2, step_req held high for 50 cycles -> exactly one clock_out pulse. Rise at k+5, fall at k+8, state back to 0; cycle_count +1.
- RUN with D=1, halt_req asserted while clock_out=1 -> clock_out completes its high phase, falls, state=0 on the fall edge, clock_out stays 0.
- Reset asserted mid-high phase in RUN -> clock_out=0 and cycle_count=0 immediately (asynchronous), state=HALT.
- BREAK_EN build, break_cycle=7, D=0, RUN -> halts with cycle_count=7, break_hit=1. run_req -> break_hit=0 on resume.

Source files
------------

// File: rtl/cpu_clock_ctrl.sv
// Run/step/halt sequencer: divides clock_in into the CPU clock and counts CPU cycles.
// Optional breakpoint ports are enabled with `define CPU_CLOCK_CTRL_BREAK_EN.
module cpu_clock_ctrl #(
   parameter int DIV_W       = 32,
   parameter int CNT_W       = 32,
   parameter int DEFAULT_DIV = 0,
   parameter int AUTO_RUN    = 0
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             run_req,
   input  logic             halt_req,
   input  logic             step_req,
   input  logic             div_load,
   input  logic [DIV_W-1:0] div_value,
`ifdef CPU_CLOCK_CTRL_BREAK_EN
   input  logic [CNT_W-1:0] break_cycle,
   output logic             break_hit,
`endif
   output logic             clock_out,
   output logic             mem_clock_out,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cycle_count,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   localparam state_t RESET_STATE = (AUTO_RUN != 0) ? ST_RUN : ST_HALT;

   state_t           state_r, state_nx_s;
   logic [DIV_W-1:0] div_reg_r, div_cnt_r, div_pend_r;
   logic             pend_valid_r;
   logic             clock_out_r, busy_r;
   logic [CNT_W-1:0] cycle_count_r;
   logic             sync1_r, sync2_r, sync3_r;
   logic             step_pulse_s, tc_s, toggle_s, stop_s, brk_s, rise_s, fall_s;

   // Push-button synchronizer with a third flop for rising-edge detection
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         sync3_r <= 1'b0;
      end else begin
         sync1_r <= step_req;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
      end
   end

   assign step_pulse_s = sync2_r & ~sync3_r;
   assign tc_s         = (state_r != ST_HALT) && (div_cnt_r >= div_reg_r);

`ifdef CPU_CLOCK_CTRL_BREAK_EN
   logic brk_done_r, break_hit_r, brk_fire_s;

   // brk_done_r keeps a resume at the same cycle_count from re-triggering the break
   assign brk_s      = (state_r == ST_RUN) && !brk_done_r && !clock_out_r &&
                       (cycle_count_r == break_cycle);
   assign brk_fire_s = brk_s & tc_s;
   assign break_hit  = break_hit_r;

   // Breakpoint bookkeeping: sticky hit flag and re-arm on the next CPU rise
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         brk_done_r  <= 1'b0;
         break_hit_r <= 1'b0;
      end else begin
         if (brk_fire_s)  brk_done_r <= 1'b1;
         else if (rise_s) brk_done_r <= 1'b0;
         else             brk_done_r <= brk_done_r;
         if (brk_fire_s)                                       break_hit_r <= 1'b1;
         else if (state_r == ST_HALT && state_nx_s != ST_HALT) break_hit_r <= 1'b0;
         else                                                  break_hit_r <= break_hit_r;
      end
   end
`else
   assign brk_s = 1'b0;
`endif

   assign stop_s = halt_req | brk_s;

   // Next-state and toggle decision; stopping only ever happens with clock_out low afterwards
   always_comb begin
      state_nx_s = state_r;
      toggle_s   = 1'b0;
      case (state_r)
         ST_HALT: begin
            if (halt_req)          state_nx_s = ST_HALT;
            else if (step_pulse_s) state_nx_s = ST_STEP;
            else if (run_req)      state_nx_s = ST_RUN;
            else                   state_nx_s = ST_HALT;
         end
         ST_RUN: begin
            if (!tc_s) begin
               state_nx_s = ST_RUN;
            end else if (!stop_s) begin
               toggle_s = 1'b1;
            end else if (clock_out_r) begin
               toggle_s   = 1'b1;
               state_nx_s = ST_HALT;
            end else begin
               state_nx_s = ST_HALT;
            end
         end
         ST_STEP: begin
            if (!tc_s) begin
               state_nx_s = ST_STEP;
            end else begin
               toggle_s   = 1'b1;
               state_nx_s = clock_out_r ? ST_HALT : ST_STEP;
            end
         end
         default: begin
            state_nx_s = ST_HALT;
         end
      endcase
   end

   assign rise_s = toggle_s & ~clock_out_r;
   assign fall_s = toggle_s &  clock_out_r;

   // State, CPU clock, divider counter and cycle counter
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         state_r       <= RESET_STATE;
         busy_r        <= (RESET_STATE != ST_HALT);
         clock_out_r   <= 1'b0;
         div_cnt_r     <= '0;
         cycle_count_r <= '0;
      end else begin
         state_r     <= state_nx_s;
         busy_r      <= (state_nx_s != ST_HALT);
         clock_out_r <= clock_out_r ^ toggle_s;
         if (state_r == ST_HALT || tc_s) div_cnt_r <= '0;
         else                            div_cnt_r <= div_cnt_r + DIV_W'(1);
         if (rise_s) cycle_count_r <= cycle_count_r + CNT_W'(1);
         else        cycle_count_r <= cycle_count_r;
      end
   end

   // Divider reload: immediate in HALT, otherwise deferred to the falling toggle
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         div_reg_r    <= DIV_W'(DEFAULT_DIV);
         div_pend_r   <= '0;
         pend_valid_r <= 1'b0;
      end else if (div_load && state_r == ST_HALT) begin
         div_reg_r    <= div_value;
         pend_valid_r <= 1'b0;
      end else if (div_load) begin
         div_pend_r   <= div_value;
         pend_valid_r <= 1'b1;
         if (fall_s && pend_valid_r) div_reg_r <= div_pend_r;
         else                        div_reg_r <= div_reg_r;
      end else if (pend_valid_r && (fall_s || state_r == ST_HALT)) begin
         div_reg_r    <= div_pend_r;
         pend_valid_r <= 1'b0;
      end else begin
         div_reg_r    <= div_reg_r;
         pend_valid_r <= pend_valid_r;
      end
   end

   assign clock_out     = clock_out_r;
   assign mem_clock_out = clock_in;
   assign state         = state_r;
   assign cycle_count   = cycle_count_r;
   assign busy          = busy_r;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl: vector table for run/divider reload plus
// hand sequences for halt, single-step, async reset and (when enabled) breakpoints.
module tb_cpu_clock_ctrl;

   logic        clock_in = 1'b0;
   logic        reset;
   logic        run_req, halt_req, step_req, div_load;
   logic [31:0] div_value;
   logic        clock_out, mem_clock_out, busy;
   logic [1:0]  state;
   logic [31:0] cycle_count;
`ifdef CPU_CLOCK_CTRL_BREAK_EN
   logic [31:0] break_cycle;
   logic        break_hit;
`endif

   int checks = 0;
   int errors = 0;

   cpu_clock_ctrl #(.DIV_W(32), .CNT_W(32), .DEFAULT_DIV(0), .AUTO_RUN(0)) dut (
      .clock_in      (clock_in),
      .reset         (reset),
      .run_req       (run_req),
      .halt_req      (halt_req),
      .step_req      (step_req),
      .div_load      (div_load),
      .div_value     (div_value),
`ifdef CPU_CLOCK_CTRL_BREAK_EN
      .break_cycle   (break_cycle),
      .break_hit     (break_hit),
`endif
      .clock_out     (clock_out),
      .mem_clock_out (mem_clock_out),
      .state         (state),
      .cycle_count   (cycle_count),
      .busy          (busy)
   );

   always #5 clock_in = ~clock_in;

   typedef struct {
      logic        run;
      logic        load;
      logic [31:0] val;
      logic        exp_clk;
      logic [1:0]  exp_state;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock_in);
      @(negedge clock_in);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int rises;
      logic prev_clk;
      reset = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
      div_load = 1'b0; div_value = 32'd0;
`ifdef CPU_CLOCK_CTRL_BREAK_EN
      break_cycle = 32'hFFFF_FFFF;
`endif
      // D=0 free-run, then a divider reload to 3 mid-run
      vq.push_back('{1'b1, 1'b0, 32'd0, 1'b0, 2'd1, 32'd0});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b1, 2'd1, 32'd1});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 2'd1, 32'd1});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b1, 2'd1, 32'd2});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 2'd1, 32'd2});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b1, 2'd1, 32'd3});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 2'd1, 32'd3});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b1, 2'd1, 32'd4});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 2'd1, 32'd4});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b1, 2'd1, 32'd5});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 2'd1, 32'd5});
      vq.push_back('{1'b0, 1'b1, 32'd3, 1'b1, 2'd1, 32'd6});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 2'd1, 32'd6});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 2'd1, 32'd6});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 2'd1, 32'd6});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 2'd1, 32'd6});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b1, 2'd1, 32'd7});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b1, 2'd1, 32'd7});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b1, 2'd1, 32'd7});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b1, 2'd1, 32'd7});
      vq.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 2'd1, 32'd7});

      repeat (2) @(negedge clock_in);
      reset = 1'b0;
      tick();
      check("reset clock_out", {31'd0, clock_out}, 32'd0);
      check("reset state", {30'd0, state}, 32'd0);
      check("reset cycle_count", cycle_count, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("mem_clock low", {31'd0, mem_clock_out}, 32'd0);
      @(posedge clock_in); #2;
      check("mem_clock high", {31'd0, mem_clock_out}, 32'd1);
      @(negedge clock_in);

      for (int i = 0; i < vq.size(); i++) begin
         run_req = vq[i].run; div_load = vq[i].load; div_value = vq[i].val;
         tick();
         check($sformatf("vec%0d clock_out", i), {31'd0, clock_out}, {31'd0, vq[i].exp_clk});
         check($sformatf("vec%0d state", i), {30'd0, state}, {30'd0, vq[i].exp_state});
         check($sformatf("vec%0d cycle_count", i), cycle_count, vq[i].exp_cnt);
      end
      run_req = 1'b0; div_load = 1'b0;

      // Halt with clock_out already low: wait for the period boundary, no toggle
      halt_req = 1'b1;
      repeat (3) tick();
      check("halt_lo pending state", {30'd0, state}, 32'd1);
      tick();
      check("halt_lo state", {30'd0, state}, 32'd0);
      check("halt_lo clock_out", {31'd0, clock_out}, 32'd0);
      check("halt_lo cycle_count", cycle_count, 32'd7);
      check("halt_lo busy", {31'd0, busy}, 32'd0);
      halt_req = 1'b0;

      // D=1 run, halt requested during the high phase
      div_load = 1'b1; div_value = 32'd1; tick(); div_load = 1'b0;
      run_req = 1'b1; tick(); run_req = 1'b0;
      check("d1 run state", {30'd0, state}, 32'd1);
      tick();
      check("d1 low phase", {31'd0, clock_out}, 32'd0);
      tick();
      check("d1 rise", {31'd0, clock_out}, 32'd1);
      check("d1 rise count", cycle_count, 32'd8);
      halt_req = 1'b1;
      tick();
      check("halt_hi still high", {31'd0, clock_out}, 32'd1);
      check("halt_hi still run", {30'd0, state}, 32'd1);
      tick();
      check("halt_hi fall", {31'd0, clock_out}, 32'd0);
      check("halt_hi state", {30'd0, state}, 32'd0);
      tick();
      check("halt_hi stays low", {31'd0, clock_out}, 32'd0);
      check("halt_hi count", cycle_count, 32'd8);
      halt_req = 1'b0;

      // Single step with D=2, button held for 50 cycles
      div_load = 1'b1; div_value = 32'd2; tick(); div_load = 1'b0;
      step_req = 1'b1;
      rises = 0;
      prev_clk = clock_out;
      for (int i = 1; i <= 50; i++) begin
         tick();
         if (clock_out && !prev_clk) rises++;
         prev_clk = clock_out;
         if (i == 2) check("step k+1 state", {30'd0, state}, 32'd0);
         if (i == 3) check("step k+2 state", {30'd0, state}, 32'd2);
         if (i == 5) check("step k+4 clock_out", {31'd0, clock_out}, 32'd0);
         if (i == 6) begin
            check("step k+5 rise", {31'd0, clock_out}, 32'd1);
            check("step k+5 count", cycle_count, 32'd9);
            check("step busy", {31'd0, busy}, 32'd1);
         end
         if (i == 8) check("step k+7 high", {31'd0, clock_out}, 32'd1);
         if (i == 9) begin
            check("step k+8 fall", {31'd0, clock_out}, 32'd0);
            check("step k+8 state", {30'd0, state}, 32'd0);
         end
      end
      check("step pulses while held", rises, 32'd1);
      check("step final count", cycle_count, 32'd9);
      step_req = 1'b0;
      repeat (3) tick();
      check("step released state", {30'd0, state}, 32'd0);

      // Asynchronous reset during the high phase
      run_req = 1'b1; tick(); run_req = 1'b0;
      for (int i = 0; i < 10 && !clock_out; i++) tick();
      check("pre-reset high", {31'd0, clock_out}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async reset clock_out", {31'd0, clock_out}, 32'd0);
      check("async reset count", cycle_count, 32'd0);
      check("async reset state", {30'd0, state}, 32'd0);
      @(negedge clock_in);
      reset = 1'b0;
      tick();
      check("post-reset state", {30'd0, state}, 32'd0);

`ifdef CPU_CLOCK_CTRL_BREAK_EN
      // Breakpoint at cycle 7 with D=0, then resume
      break_cycle = 32'd7;
      run_req = 1'b1; tick(); run_req = 1'b0;
      for (int i = 0; i < 40 && state != 2'd0; i++) tick();
      check("break state", {30'd0, state}, 32'd0);
      check("break count", cycle_count, 32'd7);
      check("break hit", {31'd0, break_hit}, 32'd1);
      check("break clock_out", {31'd0, clock_out}, 32'd0);
      run_req = 1'b1; tick(); run_req = 1'b0;
      check("resume break_hit", {31'd0, break_hit}, 32'd0);
      check("resume state", {30'd0, state}, 32'd1);
      tick();
      check("resume rise", {31'd0, clock_out}, 32'd1);
      check("resume count", cycle_count, 32'd8);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
